// File: rtl/ec_mul_arbiter.sv
// rtl/ec_mul_arbiter.sv - round-robin sharing of one EC scalar multiplier between two requesters
module ec_mul_arbiter #(
  parameter int WIDTH   = 256,
  parameter int TIMEOUT = 4096
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] k0,
  input  logic [WIDTH-1:0] k1,
  input  logic [WIDTH-1:0] px0,
  input  logic [WIDTH-1:0] py0,
  input  logic [WIDTH-1:0] px1,
  input  logic [WIDTH-1:0] py1,
  output logic             done0,
  output logic             done1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic [WIDTH-1:0] outx,
  output logic [WIDTH-1:0] outy,
  output logic             inf,
  output logic             err,
  output logic             mul_start,
  output logic             mul_abort,
  output logic [WIDTH-1:0] mul_k,
  output logic [WIDTH-1:0] mul_x,
  output logic [WIDTH-1:0] mul_y,
  input  logic [WIDTH-1:0] mul_outx,
  input  logic [WIDTH-1:0] mul_outy,
  input  logic             mul_done
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;

  state_t           state;
  logic             last;
  logic [CW-1:0]    cnt;
  logic             any_req;
  logic             pick1;
  logic [WIDTH-1:0] sel_k;
  logic [WIDTH-1:0] sel_x;
  logic [WIDTH-1:0] sel_y;
  logic             release_req;

  // Winner selection: a lone request wins, a tie goes to the side not served last
  always_comb begin
    any_req     = req0 | req1;
    pick1       = req1 & (~req0 | ~last);
    sel_k       = pick1 ? k1  : k0;
    sel_x       = pick1 ? px1 : px0;
    sel_y       = pick1 ? py1 : py0;
    release_req = (gnt[0] & ~req0) | (gnt[1] & ~req1);
  end

  // Sequencer: grant, start, watchdog wait, hand back result and wait for req release
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      last      <= 1'b1;
      cnt       <= '0;
      gnt       <= 2'b00;
      busy      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      inf       <= 1'b0;
      err       <= 1'b0;
      mul_start <= 1'b0;
      mul_abort <= 1'b0;
      outx      <= '0;
      outy      <= '0;
      mul_k     <= '0;
      mul_x     <= '0;
      mul_y     <= '0;
    end else begin
      mul_start <= 1'b0;
      mul_abort <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt   <= pick1 ? 2'b10 : 2'b01;
            last  <= pick1;
            busy  <= 1'b1;
            mul_k <= sel_k;
            mul_x <= sel_x;
            mul_y <= sel_y;
            inf   <= 1'b0;
            err   <= 1'b0;
            if (sel_k == '0) begin
              // k = 0 yields the point at infinity without touching the multiplier
              state <= DONE;
              outx  <= '0;
              outy  <= '0;
              inf   <= 1'b1;
              done0 <= ~pick1;
              done1 <= pick1;
            end else begin
              state     <= LOAD;
              mul_start <= 1'b1;
            end
          end
        end
        LOAD: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (mul_done) begin
            outx  <= mul_outx;
            outy  <= mul_outy;
            state <= DONE;
            done0 <= gnt[0];
            done1 <= gnt[1];
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            mul_abort <= 1'b1;
            err       <= 1'b1;
            outx      <= '0;
            outy      <= '0;
            state     <= DONE;
            done0     <= gnt[0];
            done1     <= gnt[1];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (release_req) begin
            state <= IDLE;
            gnt   <= 2'b00;
            busy  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ec_mul_arbiter.md
# ec_mul_arbiter

Round-robin arbiter and sequencer that shares one 256-bit elliptic-curve scalar point multiplier between two requesters, e.g. the ElGamal encrypt and decrypt engines. Each requester issues (k, Px, Py) with a four-phase req/done handshake. The arbiter latches the winner's operands, starts the multiplier, and waits for completion with a watchdog. It returns the product point to the winner, bypassing the multiplier for k = 0.

## Interface
- WIDTH, 256, field/scalar width
- TIMEOUT, 4096, max WAIT cycles before abort (≥ 2)

- Clk  in  1  clock
- Reset  in  1  synchronous active-high reset
- req0, req1  in  1 each  request level, held until matching done seen
- k0, k1  in  WIDTH each  scalar
- px0, py0, px1, py1  in  WIDTH each  affine base point
- done0, done1  out  1 each  completion level to the granted requester
- gnt  out  2  one-hot grant; 00 when idle
- busy  out  1  high in any state but IDLE
- outx, outy  out  WIDTH each  result point, valid while a done is high
- inf  out  1  result is point at infinity (k = 0)
- err  out  1  watchdog expired; outx/outy = 0
- mul_start  out  1  one-cycle start pulse to multiplier
- mul_abort  out  1  one-cycle abort pulse to multiplier
- mul_k, mul_x, mul_y  out  WIDTH each  latched operands, stable from LOAD until IDLE
- mul_outx, mul_outy  in  WIDTH each  multiplier result
- mul_done  in  1  multiplier completion pulse

## Operation
- States: IDLE, LOAD, WAIT, DONE. All outputs are registered.
- Reset forces the following, regardless of state:
  - state = IDLE; last = 1, so requester 0 wins the first tie.
  - All outputs 0: gnt = 00, busy, done0/1, inf, err, mul_start, mul_abort; outx, outy, mul_k, mul_x, mul_y.
- IDLE: requests are sampled only here.
  - Only one req high: that requester wins.
  - Both high: the requester not equal to last wins.
  - On grant: set gnt, update last, latch k/px/py into mul_k/mul_x/mul_y, clear inf/err.
  - k = 0: go straight to DONE with outx = outy = 0 and inf = 1; multiplier untouched.
  - Otherwise go to LOAD.
- LOAD: mul_start = 1 for exactly this cycle; clear watchdog counter; go to WAIT.
- WAIT: count cycles.
  - mul_done sampled high: latch mul_outx/mul_outy into outx/outy, go to DONE.
  - Count reaches TIMEOUT first: mul_abort = 1 for one cycle, err = 1, outx = outy = 0, go to DONE.
  - If mul_done and timeout occur on the same edge, mul_done wins.
- DONE: done of the granted requester = 1, other done = 0. Hold until that requester's req is sampled low, then go to IDLE with gnt = 00, done = 0. outx/outy/inf/err hold until the next grant.
- mul_done outside WAIT is ignored; this covers stale completions after reset or abort.
- Operands changing after the grant edge have no effect.
- The losing requester's req stays pending and is served on the first IDLE cycle.

## Timing
- Edges numbered from the one that samples req high in IDLE (E0).
- Normal path:
  - E0: grant.
  - Cycle E0→E1: mul_start high.
  - WAIT begins after E1.
  - Edge sampling mul_done: done high from the following cycle.
  - Overhead: 2 cycles before multiplier start, 1 cycle after mul_done.
- k = 0: done high in the cycle after E0.
- Timeout: err/done assert TIMEOUT + 1 cycles after mul_start's cycle.
- Release: done drops one cycle after req is sampled low. A pending other requester is granted on the next edge, giving a 1-cycle IDLE gap.
- Throughput: at most one multiplication in flight; no queuing beyond the two req lines.
- Reset mid-operation: all outputs are 0 on the cycle after the reset edge. The multiplier shares Reset and is reset simultaneously.

## Test plan
- Single request, multiplier model latency 20:
  - Stimulus: req0 = 1, k0 = 3, (px0, py0) = (0x2F8BDE4D…EFE4, 0xD8AC2226…62D6).
  - Required: gnt = 01; mul_start high 1 cycle after grant; done0 high 1 cycle after mul_done; outx/outy equal model output, inf = 0, err = 0.
  - Dropping req0 gives done0 = 0, gnt = 00 one cycle later.
- Contention:
  - Stimulus: after reset, req0 and req1 rise on the same cycle.
  - Required: req0 served first and req1 right after DONE/IDLE. A repeated simultaneous request is then served req0 first (last = 1). Each done only pulses its own requester.
- Zero scalar:
  - Stimulus: req1 with k1 = 0.
  - Required: done1 high 2 cycles after req1 rise; outx = outy = 0; inf = 1; mul_start never asserted.
- Watchdog:
  - Stimulus: TIMEOUT = 16, model never asserts mul_done.
  - Required: mul_abort pulses once; err = 1, done0 = 1 exactly 17 cycles after mul_start; outx = outy = 0.
  - A later stray mul_done in DONE/IDLE changes nothing.
- Reset mid-WAIT:
  - Stimulus: Reset asserted 5 cycles into WAIT.
  - Required: all outputs 0 the next cycle.
  - A new req0 (k0 = 5) is then served with normal latency and correct result.
- Held request:
  - Stimulus: req0 held 10 cycles past done0 while req1 is pending.
  - Required: done0 stays high and gnt = 01 throughout; gnt = 10 one edge after done0 falls.
